// File: rtl/twos_complement_serial.sv
// Chunk-serial two's-complement negator: CHUNK bits per cycle, LSB chunk first.
// Optional `TWOS_COMPLEMENT_ABS_EN adds abs_mode (negate only negative operands).

// One bit of the negation ripple: b = a ^ (any lower bit set).
module tcs_bit (
  input  logic a,
  input  logic p_in,
  input  logic neg,
  output logic b,
  output logic p_out
);
  assign b     = a ^ (p_in & neg);
  assign p_out = p_in | a;
endmodule

module twos_complement_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef TWOS_COMPLEMENT_ABS_EN
  input  logic             abs_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state;
  logic [WIDTH-1:0] a_q, res_q, res_shift;
  logic [IW-1:0]    idx;
  logic             pflag, neg_q, ovf_q, neg_in;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic [CHUNK:0]   p_chain;

`ifdef TWOS_COMPLEMENT_ABS_EN
  assign neg_in = !abs_mode || in_data[WIDTH-1];
`else
  assign neg_in = 1'b1;
`endif

  // Operand shifts right each cycle so the active chunk is always the low CHUNK bits.
  assign chunk_a    = a_q[CHUNK-1:0];
  assign p_chain[0] = pflag;

  tcs_bit u_bit [CHUNK-1:0] (
    .a     (chunk_a),
    .p_in  (p_chain[CHUNK-1:0]),
    .neg   ({CHUNK{neg_q}}),
    .b     (chunk_b),
    .p_out (p_chain[CHUNK:1])
  );

  // Result fills from the top; after NCHUNK shifts chunk 0 lands at the LSB.
  assign res_shift = WIDTH'({chunk_b, res_q} >> CHUNK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      res_q     <= '0;
      idx       <= '0;
      pflag     <= 1'b0;
      neg_q     <= 1'b1;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_q      <= in_data;
          neg_q    <= neg_in;
          ovf_q    <= (in_data == {1'b1, {(WIDTH-1){1'b0}}});
          res_q    <= '0;
          idx      <= '0;
          pflag    <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= BUSY;
        end
        BUSY: begin
          a_q   <= a_q >> CHUNK;
          res_q <= res_shift;
          pflag <= p_chain[CHUNK];
          idx   <= idx + 1'b1;
          if (idx == IW'(NCHUNK-1)) begin
            out_valid <= 1'b1;
            out_data  <= res_shift;
            out_ovf   <= ovf_q;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_ovf   <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_twos_complement_serial.sv
// Scoreboard bench: five DUTs (CHUNK = 1,2,4,8,16 at WIDTH=16) against a -a mod 2^16 model.
module tb_twos_complement_serial;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errs = 0, checks = 0, done_cnt = 0;

`ifdef TWOS_COMPLEMENT_ABS_EN
  localparam bit ABS = 1'b1;
`else
  localparam bit ABS = 1'b0;
`endif

  typedef struct {
    logic [15:0] d;
    logic        o;
    int          ec;
    bit          seen;
  } exp_t;

  task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s chunk=%0d got=%h want=%h t=%0t", nm, ch, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input int ch);
    checks++;
    errs++;
    $display("FAIL %s chunk=%0d t=%0t", nm, ch, $time);
  endtask

  // {ovf, result}: negate modulo 2^16, or pass non-negatives through in abs mode
  function automatic logic [16:0] model(input logic [15:0] a, input bit am);
    int v, r;
    v = int'(a);
    if (am && v < 32768) r = v;
    else                 r = (65536 - v) % 65536;
    return {v == 32768, r[15:0]};
  endfunction

  for (genvar gi = 0; gi < 5; gi++) begin : g
    localparam int CH  = 1 << gi;
    localparam int NCH = 16 / CH;

    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_ovf, busy, abs_mode;
    logic [15:0] in_data, out_data;
    int          rdy_mode;
    exp_t        q[$];

    twos_complement_serial #(.WIDTH(16), .CHUNK(CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef TWOS_COMPLEMENT_ABS_EN
      .abs_mode  (abs_mode),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .busy      (busy)
    );

    initial begin
      out_ready = 1'b1;
      forever begin
        @(posedge clk); #1;
        out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end

    // Monitor
    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        bit inflight;
        inflight = (q.size() > 0) && (cyc >= q[0].ec - NCH);
        chk("busy", CH, busy, inflight);
        chk("in_ready", CH, in_ready, !inflight);
        if (!out_valid) begin
          chk("idle_out_zero", CH, {out_ovf, out_data}, 0);
          if (q.size() > 0 && cyc > q[0].ec) begin
            fail("latency_late", CH);
            void'(q.pop_front());
          end
        end else if (q.size() == 0) begin
          fail("unexpected_out", CH);
        end else begin
          if (!q[0].seen) begin
            chk("latency", CH, cyc, q[0].ec);
            q[0].seen = 1'b1;
          end
          chk("out_data", CH, out_data, q[0].d);
          chk("out_ovf", CH, out_ovf, q[0].o);
          if (out_ready) void'(q.pop_front());
        end
      end
    end

    task automatic send(input logic [15:0] a, input bit am);
      int w;
      logic [16:0] r;
      w = 0;
      while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
      if (!in_ready) begin fail("accept_timeout", CH); return; end
      in_valid = 1'b1;
      in_data  = a;
      abs_mode = am;
      r = model(a, abs_mode & ABS);
      q.push_back('{d: r[15:0], o: r[16], ec: cyc + 1 + NCH, seen: 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int w;
      w = 0;
      while (q.size() != 0 && w < 500) begin @(posedge clk); #1; w++; end
      if (q.size() != 0) fail("drain_timeout", CH);
    endtask

    // Driver
    initial begin
      int w;
      logic [15:0] a;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; abs_mode = 1'b0; rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", CH, in_ready, 1);
      chk("rst_out_valid", CH, out_valid, 0);
      chk("rst_out_data", CH, out_data, 0);
      chk("rst_out_ovf", CH, out_ovf, 0);
      chk("rst_busy", CH, busy, 0);
      rst_n = 1'b1;

      send(16'h0001, 1'b0);
      send(16'h8000, 1'b0);
      send(16'h0000, 1'b0);
      wait_idle();

      // Backpressure with ignored in_valid while DONE
      rdy_mode = 2;
      send(16'h1234, 1'b0);
      w = 0;
      while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
      if (!out_valid) fail("bp_no_valid", CH);
      in_valid = 1'b1;
      in_data  = 16'hAAAA;
      repeat (3) begin
        chk("bp_hold_data", CH, out_data, 16'hEDCC);
        chk("bp_in_ready", CH, in_ready, 0);
        @(posedge clk); #1;
      end
      rdy_mode = 0;
      w = 0;
      while (out_valid && w < 20) begin @(posedge clk); #1; w++; end
      in_valid = 1'b0;
      if (out_valid) fail("bp_release", CH);
      wait_idle();

      // Reset mid-operation aborts without output
      send(16'h5555, 1'b0);
      if (NCH > 1) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_in_ready", CH, in_ready, 1);
      chk("abort_busy", CH, busy, 0);
      chk("abort_out_valid", CH, out_valid, 0);
      send(16'h00FF, 1'b0);
      wait_idle();

`ifdef TWOS_COMPLEMENT_ABS_EN
      send(16'hFFFB, 1'b1);
      send(16'h0007, 1'b1);
      send(16'h8000, 1'b1);
      wait_idle();
`endif

      rdy_mode = 1;
      repeat (500) begin
        case ($urandom_range(0, 7))
          0:       a = 16'h0000;
          1:       a = 16'h8000;
          2:       a = 16'hFFFF;
          3:       a = 16'h7FFF;
          default: a = 16'($urandom);
        endcase
        send(a, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      wait_idle();
      rdy_mode = 0;
      done_cnt++;
    end
  end

  initial begin
    fork
      wait (done_cnt == 5);
      begin
        #500000;
        fail("watchdog", 0);
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
